// File: rtl/l1b_clk_pkg.sv
// Shared definitions for the L1B CPU clock switch: state encoding, counter widths
// and state-decode helpers.
package l1b_clk_pkg;

    localparam int DIV_W          = 4;
    localparam int WDOG_W         = 8;
    localparam int WDOG_LIMIT_DEF = 255;

    typedef logic [2:0] state_t;

    localparam state_t ST_FAST_LO   = 3'd0;
    localparam state_t ST_FAST_HI   = 3'd1;
    localparam state_t ST_SYNC_WAIT = 3'd2;
    localparam state_t ST_HOST_LO   = 3'd3;
    localparam state_t ST_HOST_HI   = 3'd4;
    localparam state_t ST_RESYNC    = 3'd5;

    function automatic logic phi2_high(input state_t s);
        return (s == ST_FAST_HI) || (s == ST_HOST_HI);
    endfunction

    function automatic logic host_xfer(input state_t s);
        return (s == ST_HOST_LO) || (s == ST_HOST_HI);
    endfunction

    // States in which the block depends on bbc_phi0 edges to make progress.
    function automatic logic host_wait(input state_t s);
        return (s == ST_SYNC_WAIT) || host_xfer(s);
    endfunction

endpackage

// File: rtl/host_clk_switch_if.sv
// Host-bus side signals of the clock switch, plus debug visibility of the FSM state.
interface host_clk_switch_if;
    // Protocol: host_sel is only qualified in the last hsclk of a FAST_LO phase;
    // host_cyc frames a host transfer and dbuf_le is a single-hsclk strobe inside it.
    logic       bbc_phi0;
    logic       rdy;
    logic       host_sel;
    logic       cpu_phi2;
    logic       host_cyc;
    logic       dbuf_le;
    logic       host_timeout;
    logic [2:0] dbg_state;
    logic       dbg_phi0_s;

    modport master (
        output bbc_phi0, rdy, host_sel,
        input  cpu_phi2, host_cyc, dbuf_le, host_timeout, dbg_state, dbg_phi0_s
    );

    modport slave (
        input  bbc_phi0, rdy, host_sel,
        output cpu_phi2, host_cyc, dbuf_le, host_timeout, dbg_state, dbg_phi0_s
    );
endinterface

// File: rtl/phi0_sync.sv
// Multi-stage synchroniser for bbc_phi0 and rdy into hsclk, with phi0 edge detection.
module phi0_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic hsclk,
    input  logic reset,
    input  logic bbc_phi0,
    input  logic rdy,
    output logic phi0_s,
    output logic rise,
    output logic fall,
    output logic rdy_s
);

    logic [SYNC_STAGES-1:0] phi0_sr_q, phi0_sr_d;
    logic [SYNC_STAGES-1:0] rdy_sr_q, rdy_sr_d;
    logic                   phi0_q, phi0_d;

    always_comb begin
        phi0_sr_d = {phi0_sr_q[SYNC_STAGES-2:0], bbc_phi0};
        rdy_sr_d  = {rdy_sr_q[SYNC_STAGES-2:0], rdy};
        phi0_d    = phi0_sr_q[SYNC_STAGES-1];
    end

    always_ff @(posedge hsclk or posedge reset) begin
        if (reset) begin
            phi0_sr_q <= '0;
            rdy_sr_q  <= '0;
            phi0_q    <= 1'b0;
        end else begin
            phi0_sr_q <= phi0_sr_d;
            rdy_sr_q  <= rdy_sr_d;
            phi0_q    <= phi0_d;
        end
    end

    assign phi0_s = phi0_sr_q[SYNC_STAGES-1];
    assign rdy_s  = rdy_sr_q[SYNC_STAGES-1];
    assign rise   = phi0_s & ~phi0_q;
    assign fall   = ~phi0_s & phi0_q;

endmodule

// File: rtl/host_clk_switch.sv
// 65816 PHI2 generator: fast divided clock from hsclk, stretched and phase-locked to
// bbc_phi0 for host-bus cycles. Optional host-clock watchdog under macro HOST_WDOG_EN.
module host_clk_switch
    import l1b_clk_pkg::*;
#(
    parameter int FAST_DIV      = 1,
    parameter int SYNC_STAGES   = 2,
    parameter int RESYNC_CYCLES = 1,
    parameter int WDOG_LIMIT    = WDOG_LIMIT_DEF
) (
    input  logic               hsclk,
    input  logic               reset,
    host_clk_switch_if.slave   bus
);

    if (FAST_DIV < 1 || FAST_DIV > 15) begin : g_bad_fast_div
        $error("FAST_DIV out of range");
    end
    if (SYNC_STAGES < 2 || SYNC_STAGES > 3) begin : g_bad_sync_stages
        $error("SYNC_STAGES out of range");
    end
    if (RESYNC_CYCLES < 1 || RESYNC_CYCLES > 7) begin : g_bad_resync
        $error("RESYNC_CYCLES out of range");
    end
    if (WDOG_LIMIT < 1 || WDOG_LIMIT > (2 ** WDOG_W) - 1) begin : g_bad_wdog
        $error("WDOG_LIMIT out of range");
    end

    localparam logic [DIV_W-1:0] FAST_LAST   = DIV_W'(FAST_DIV - 1);
    localparam logic [DIV_W-1:0] RESYNC_LAST = DIV_W'(RESYNC_CYCLES - 1);

    logic phi0_s, rise, fall, rdy_s;

    phi0_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_phi0_sync (
        .hsclk    (hsclk),
        .reset    (reset),
        .bbc_phi0 (bus.bbc_phi0),
        .rdy      (bus.rdy),
        .phi0_s   (phi0_s),
        .rise     (rise),
        .fall     (fall),
        .rdy_s    (rdy_s)
    );

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             cpu_phi2_q, cpu_phi2_d;
    logic             host_cyc_q, host_cyc_d;
    logic             dbuf_le_c;

`ifdef HOST_WDOG_EN
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_LIMIT);
    logic [WDOG_W-1:0] wdog_q, wdog_d;
    logic              timeout_q, timeout_d;
`endif

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        dbuf_le_c = 1'b0;

        case (state_q)
            ST_FAST_LO: begin
                if (div_q == FAST_LAST) begin
                    div_d   = '0;
                    state_d = bus.host_sel ? ST_SYNC_WAIT : ST_FAST_HI;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            ST_FAST_HI: begin
                if (div_q == FAST_LAST) begin
                    div_d   = '0;
                    state_d = ST_FAST_LO;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            ST_SYNC_WAIT: begin
                if (fall) state_d = ST_HOST_LO;
            end
            ST_HOST_LO: begin
                if (rise) state_d = ST_HOST_HI;
            end
            ST_HOST_HI: begin
                // Data is valid on the phi0 falling edge; a low rdy repeats the host cycle.
                if (fall) begin
                    dbuf_le_c = 1'b1;
                    state_d   = rdy_s ? ST_RESYNC : ST_HOST_LO;
                end
            end
            ST_RESYNC: begin
                if (div_q == RESYNC_LAST) begin
                    div_d   = '0;
                    state_d = ST_FAST_LO;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            default: begin
                div_d   = '0;
                state_d = ST_FAST_LO;
            end
        endcase

`ifdef HOST_WDOG_EN
        wdog_d    = '0;
        timeout_d = timeout_q;
        if (host_wait(state_q)) begin
            if (wdog_q == WDOG_LAST) begin
                state_d   = ST_RESYNC;
                div_d     = '0;
                dbuf_le_c = 1'b0;
                timeout_d = 1'b1;
            end else if (!(rise || fall)) begin
                wdog_d = wdog_q + 1'b1;
            end
        end
`endif

        cpu_phi2_d = phi2_high(state_d);
        host_cyc_d = host_xfer(state_d);
    end

    always_ff @(posedge hsclk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_FAST_LO;
            div_q      <= '0;
            cpu_phi2_q <= 1'b0;
            host_cyc_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            cpu_phi2_q <= cpu_phi2_d;
            host_cyc_q <= host_cyc_d;
        end
    end

`ifdef HOST_WDOG_EN
    always_ff @(posedge hsclk or posedge reset) begin
        if (reset) begin
            wdog_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            wdog_q    <= wdog_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.host_timeout = timeout_q;
`else
    assign bus.host_timeout = 1'b0;
`endif

    assign bus.cpu_phi2   = cpu_phi2_q;
    assign bus.host_cyc   = host_cyc_q;
    assign bus.dbuf_le    = dbuf_le_c;
    assign bus.dbg_state  = state_q;
    assign bus.dbg_phi0_s = phi0_s;

endmodule

// File: tb/tb_host_clk_switch.sv
// Directed bench for host_clk_switch with default parameters (FAST_DIV=1, SYNC_STAGES=2,
// RESYNC_CYCLES=1); watchdog sequence only when HOST_WDOG_EN is defined.
module tb_host_clk_switch;

    localparam logic [2:0] S_FL = 3'd0;
    localparam logic [2:0] S_FH = 3'd1;
    localparam logic [2:0] S_SW = 3'd2;
    localparam logic [2:0] S_HL = 3'd3;
    localparam logic [2:0] S_HH = 3'd4;
    localparam logic [2:0] S_RS = 3'd5;

    typedef struct packed {
        logic       sel;
        logic       phi0;
        logic       rdy;
        logic       e_phi2;
        logic       e_hc;
        logic       e_dle;
        logic [2:0] e_st;
    } vec_t;

    logic hsclk;
    logic reset;
    int   total;
    int   bad;
    int   bstep;
    int   rdy_from;
    vec_t vecs[$];

    host_clk_switch_if bus ();

    host_clk_switch dut (
        .hsclk (hsclk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        hsclk = 1'b0;
        forever #5 hsclk = ~hsclk;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: got no finish, want finish");
        $fatal(1, "bench timeout");
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic sel, input logic ph, input logic r);
        bus.host_sel = sel;
        bus.bbc_phi0 = ph;
        bus.rdy      = r;
        @(posedge hsclk);
        @(negedge hsclk);
    endtask

    task automatic do_reset(input logic check);
        reset        = 1'b1;
        bus.host_sel = 1'b0;
        bus.bbc_phi0 = 1'b0;
        bus.rdy      = 1'b1;
        repeat (2) @(negedge hsclk);
        if (check) begin
            chk("rst.phi2",    {7'd0, bus.cpu_phi2},     8'd0);
            chk("rst.hc",      {7'd0, bus.host_cyc},     8'd0);
            chk("rst.dle",     {7'd0, bus.dbuf_le},      8'd0);
            chk("rst.timeout", {7'd0, bus.host_timeout}, 8'd0);
            chk("rst.state",   {5'd0, bus.dbg_state},    {5'd0, S_FL});
        end
        reset = 1'b0;
    endtask

    task automatic add_raw(input logic sel, input logic ph, input logic r,
                           input logic p2, input logic hc, input logic dl, input logic [2:0] st);
        vecs.push_back('{sel:sel, phi0:ph, rdy:r, e_phi2:p2, e_hc:hc, e_dle:dl, e_st:st});
    endtask

    // bbc_phi0: high for the first two steps, then 8 low / 8 high from step 3 (period 16).
    task automatic add_host(input logic sel, input logic p2, input logic hc,
                            input logic dl, input logic [2:0] st);
        logic ph;
        logic r;
        bstep++;
        ph = (bstep < 3) ? 1'b1 : (((bstep - 3) % 16) >= 8);
        r  = (bstep > rdy_from);
        add_raw(sel, ph, r, p2, hc, dl, st);
    endtask

    task automatic build_host(input int n_per);
        vecs.delete();
        bstep    = 0;
        rdy_from = 16 * (n_per - 1) + 4;
        for (int i = 0; i < 4; i++) add_host(1'b1, 1'b0, 1'b0, 1'b0, S_SW);
        for (int i = 0; i < 8; i++) add_host(1'b1, 1'b0, 1'b1, 1'b0, S_HL);
        for (int p = 0; p < n_per; p++) begin
            if (p > 0)
                for (int i = 0; i < 8; i++) add_host(1'b0, 1'b0, 1'b1, 1'b0, S_HL);
            for (int i = 0; i < 7; i++) add_host(1'b0, 1'b1, 1'b1, 1'b0, S_HH);
            add_host(1'b0, 1'b1, 1'b1, 1'b1, S_HH);
        end
        add_host(1'b0, 1'b0, 1'b0, 1'b0, S_RS);
        add_host(1'b0, 1'b0, 1'b0, 1'b0, S_FL);
        add_host(1'b0, 1'b1, 1'b0, 1'b0, S_FH);
        add_host(1'b0, 1'b0, 1'b0, 1'b0, S_FL);
    endtask

    task automatic run_vecs(input string tag, input int nmax);
        for (int i = 0; i < vecs.size() && i < nmax; i++) begin
            step(vecs[i].sel, vecs[i].phi0, vecs[i].rdy);
            chk($sformatf("%s[%0d].phi2", tag, i),  {7'd0, bus.cpu_phi2}, {7'd0, vecs[i].e_phi2});
            chk($sformatf("%s[%0d].hc", tag, i),    {7'd0, bus.host_cyc}, {7'd0, vecs[i].e_hc});
            chk($sformatf("%s[%0d].dle", tag, i),   {7'd0, bus.dbuf_le},  {7'd0, vecs[i].e_dle});
            chk($sformatf("%s[%0d].state", tag, i), {5'd0, bus.dbg_state}, {5'd0, vecs[i].e_st});
        end
    endtask

    task automatic phase_sweep();
        for (int off = 0; off < 32; off++) begin
            int   bad_st, dle_cnt, dle_bad, hc_len, hc_runs, bad_run, host_hi, run;
            logic hc_prev, ph;
            bad_st = 0; dle_cnt = 0; dle_bad = 0; hc_len = 0; hc_runs = 0;
            bad_run = 0; host_hi = 0; run = 0; hc_prev = 1'b0;
            do_reset(1'b0);
            for (int n = 1; n <= 64; n++) begin
                ph = (((n + off) % 16) >= 8);
                step(n == 1, ph, 1'b1);
                if (bus.dbg_state > S_RS) bad_st++;
                if (bus.dbuf_le) begin
                    dle_cnt++;
                    if (!(bus.cpu_phi2 && bus.host_cyc)) dle_bad++;
                end
                if (bus.host_cyc) begin
                    hc_len++;
                    if (!hc_prev) hc_runs++;
                end
                hc_prev = bus.host_cyc;
                if (bus.cpu_phi2) begin
                    run++;
                end else if (run > 0) begin
                    if (run != 1 && run != 8) bad_run++;
                    if (run == 8) host_hi++;
                    run = 0;
                end
            end
            chk($sformatf("sweep%0d.bad_state", off), 8'(bad_st),  8'd0);
            chk($sformatf("sweep%0d.dle_cnt", off),   8'(dle_cnt), 8'd1);
            chk($sformatf("sweep%0d.dle_ctx", off),   8'(dle_bad), 8'd0);
            chk($sformatf("sweep%0d.hc_len", off),    8'(hc_len),  8'd16);
            chk($sformatf("sweep%0d.hc_runs", off),   8'(hc_runs), 8'd1);
            chk($sformatf("sweep%0d.hi_runs", off),   8'(bad_run), 8'd0);
            chk($sformatf("sweep%0d.host_hi", off),   8'(host_hi), 8'd1);
        end
    endtask

`ifdef HOST_WDOG_EN
    task automatic wdog_test();
        int hit_at, dle_seen, hc_seen, highs, lost;
        hit_at = 0; dle_seen = 0; hc_seen = 0; highs = 0; lost = 0;
        do_reset(1'b0);
        step(1'b1, 1'b0, 1'b1);
        for (int n = 2; n <= 300 && hit_at == 0; n++) begin
            step(1'b0, 1'b0, 1'b1);
            if (bus.dbuf_le) dle_seen++;
            if (bus.host_cyc) hc_seen++;
            if (bus.host_timeout) hit_at = n;
        end
        chk("wdog.hit_cycle", 8'(hit_at > 255 ? hit_at - 200 : 0), 8'(257 - 200));
        chk("wdog.dle", 8'(dle_seen), 8'd0);
        chk("wdog.hc", 8'(hc_seen), 8'd0);
        chk("wdog.state", {5'd0, bus.dbg_state}, {5'd0, S_RS});
        step(1'b0, 1'b0, 1'b1);
        for (int n = 0; n < 10; n++) begin
            step(1'b0, 1'b0, 1'b1);
            if (bus.cpu_phi2) highs++;
            if (!bus.host_timeout) lost++;
        end
        chk("wdog.fast_highs", 8'(highs), 8'd5);
        chk("wdog.sticky", 8'(lost), 8'd0);
        do_reset(1'b1);
    endtask
`endif

    initial begin
        total        = 0;
        bad          = 0;
        reset        = 1'b1;
        bus.host_sel = 1'b0;
        bus.bbc_phi0 = 1'b0;
        bus.rdy      = 1'b1;

        // Fast clocking; host_sel raised during FAST_HI must be ignored.
        do_reset(1'b1);
        vecs.delete();
        for (int i = 0; i < 8; i++)
            add_raw(i % 4 == 1, 1'b0, 1'b1, i % 2 == 0, 1'b0, 1'b0, (i % 2 == 0) ? S_FH : S_FL);
        run_vecs("fast", 8);

        // Single host read, rdy high.
        do_reset(1'b1);
        build_host(1);
        run_vecs("read", 1000);

        // Host read stretched by rdy low for two host cycles.
        do_reset(1'b0);
        build_host(3);
        run_vecs("stretch", 1000);

        // Reset asserted during HOST_HI, between clock edges.
        do_reset(1'b0);
        build_host(1);
        run_vecs("pre_rst", 14);
        #2 reset = 1'b1;
        #1;
        chk("midrst.phi2",  {7'd0, bus.cpu_phi2},  8'd0);
        chk("midrst.hc",    {7'd0, bus.host_cyc},  8'd0);
        chk("midrst.dle",   {7'd0, bus.dbuf_le},   8'd0);
        chk("midrst.state", {5'd0, bus.dbg_state}, {5'd0, S_FL});
        @(negedge hsclk);
        reset = 1'b0;
        step(1'b0, 1'b0, 1'b1);
        chk("postrst.phi2",  {7'd0, bus.cpu_phi2},  8'd1);
        chk("postrst.state", {5'd0, bus.dbg_state}, {5'd0, S_FH});
        step(1'b0, 1'b0, 1'b1);
        chk("postrst.phi2b",  {7'd0, bus.cpu_phi2},  8'd0);
        chk("postrst.stateb", {5'd0, bus.dbg_state}, {5'd0, S_FL});

        phase_sweep();

`ifdef HOST_WDOG_EN
        wdog_test();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
